// File: rtl/mdu_hilo.sv
// mdu_hilo: multicycle multiply/divide unit owning the HI/LO register pair.
// A launch latches the operands and op code, then counts a fixed latency
// (5 cycles for multiplies, 10 for divides) before writing HI/LO.
// mthi/mtlo write directly while the unit is idle.
// HLout is a combinational read port selecting HI or LO.
module mdu_hilo (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  HILOop,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic [1:0]  readHL,
   output logic        busy,
   output logic [31:0] HLout,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;

   state_t      r_state;
   logic [3:0]  r_cnt;
   logic [31:0] r_opA;
   logic [31:0] r_opB;
   logic [2:0]  r_op;
   logic        r_busy;
   logic [31:0] r_hi;
   logic [31:0] r_lo;

   logic        w_launch;
   logic [63:0] w_prod_s;
   logic [63:0] w_prod_u;
   logic [31:0] w_abs_a;
   logic [31:0] w_abs_b;
   logic [31:0] w_q_mag;
   logic [31:0] w_r_mag;
   logic [31:0] w_q_s;
   logic [31:0] w_r_s;
   logic [31:0] w_q_u;
   logic [31:0] w_r_u;
   logic        w_res_wr;
   logic [31:0] w_res_hi;
   logic [31:0] w_res_lo;

   assign w_launch = start && (HILOop >= 4'd1) && (HILOop <= 4'd4);

   // Sign-extending to 64 bits makes the low 64 bits of the plain product
   // equal to the two's-complement signed product.
   assign w_prod_s = {{32{r_opA[31]}}, r_opA} * {{32{r_opB[31]}}, r_opB};
   assign w_prod_u = {32'd0, r_opA} * {32'd0, r_opB};

   // Signed division goes through magnitudes so that the most negative
   // dividend over -1 wraps cleanly instead of overflowing.
   assign w_abs_a = r_opA[31] ? (32'd0 - r_opA) : r_opA;
   assign w_abs_b = r_opB[31] ? (32'd0 - r_opB) : r_opB;
   assign w_q_mag = w_abs_a / w_abs_b;
   assign w_r_mag = w_abs_a % w_abs_b;
   assign w_q_s   = (r_opA[31] ^ r_opB[31]) ? (32'd0 - w_q_mag) : w_q_mag;
   assign w_r_s   = r_opA[31] ? (32'd0 - w_r_mag) : w_r_mag;
   assign w_q_u   = r_opA / r_opB;
   assign w_r_u   = r_opA % r_opB;

   // Select the write-back value for the latched op; a zero divisor suppresses the write.
   always_comb begin
      w_res_wr = 1'b0;
      w_res_hi = r_hi;
      w_res_lo = r_lo;
      case (r_op)
         OP_MULT: begin
            w_res_wr = 1'b1;
            w_res_hi = w_prod_s[63:32];
            w_res_lo = w_prod_s[31:0];
         end
         OP_MULTU: begin
            w_res_wr = 1'b1;
            w_res_hi = w_prod_u[63:32];
            w_res_lo = w_prod_u[31:0];
         end
         OP_DIV: begin
            w_res_wr = (r_opB != 32'd0);
            w_res_hi = w_r_s;
            w_res_lo = w_q_s;
         end
         OP_DIVU: begin
            w_res_wr = (r_opB != 32'd0);
            w_res_hi = w_r_u;
            w_res_lo = w_q_u;
         end
         default: begin
            w_res_wr = 1'b0;
            w_res_hi = r_hi;
            w_res_lo = r_lo;
         end
      endcase
   end

   // Control FSM: launch from idle, count down the latency, write back on the last cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
         r_opA   <= 32'd0;
         r_opB   <= 32'd0;
         r_op    <= 3'd0;
         r_busy  <= 1'b0;
         r_hi    <= 32'd0;
         r_lo    <= 32'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_launch) begin
                  r_opA   <= A;
                  r_opB   <= B;
                  r_op    <= HILOop[2:0];
                  r_cnt   <= (HILOop <= 4'd2) ? 4'd5 : 4'd10;
                  r_busy  <= 1'b1;
                  r_state <= S_BUSY;
               end else if (HILOop == 4'd5) begin
                  r_hi <= A;
               end else if (HILOop == 4'd6) begin
                  r_lo <= A;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_BUSY: begin
               if (r_cnt == 4'd1) begin
                  if (w_res_wr) begin
                     r_hi <= w_res_hi;
                     r_lo <= w_res_lo;
                  end
                  r_cnt   <= 4'd0;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_cnt   <= 4'd0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // Read port: HI for 01, LO for 10, zero otherwise.
   always_comb begin
      HLout = 32'd0;
      case (readHL)
         2'b01:   HLout = r_hi;
         2'b10:   HLout = r_lo;
         default: HLout = 32'd0;
      endcase
   end

   assign busy = r_busy;
   assign HI   = r_hi;
   assign LO   = r_lo;

endmodule

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: directed and randomized checks of mdu_hilo against a
// 64-bit arithmetic reference model of HI/LO.
module tb_mdu_hilo;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [3:0]  HILOop;
   logic [31:0] A;
   logic [31:0] B;
   logic [1:0]  readHL;
   logic        busy;
   logic [31:0] HLout;
   logic [31:0] HI;
   logic [31:0] LO;

   int checks = 0;
   int errors = 0;
   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;

   mdu_hilo dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .HILOop (HILOop),
      .A      (A),
      .B      (B),
      .readHL (readHL),
      .busy   (busy),
      .HLout  (HLout),
      .HI     (HI),
      .LO     (LO)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: HI/LO after an operation, from plain 64-bit arithmetic.
   task automatic model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         3'd1: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; end
         3'd2: begin p = {32'd0, a} * {32'd0, b}; m_hi = p[63:32]; m_lo = p[31:0]; end
         3'd3: if (b != 32'd0) begin q = sa / sb; r = sa % sb; m_lo = q[31:0]; m_hi = r[31:0]; end
         3'd4: if (b != 32'd0) begin m_lo = a / b; m_hi = a % b; end
         default: ;
      endcase
   endtask

   task automatic do_mt(input logic [3:0] op, input logic [31:0] a, input logic s);
      start = s; HILOop = op; A = a; B = $urandom;
      tick();
      start = 1'b0; HILOop = 4'd0;
      if (op == 4'd5) m_hi = a; else m_lo = a;
      chk("mt_hi", HI, m_hi);
      chk("mt_lo", LO, m_lo);
      chk("mt_busy", {31'd0, busy}, 32'd0);
   endtask

   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit interfere);
      int lat, n;
      logic [31:0] old_hi, old_lo;
      lat = (op <= 3'd2) ? 5 : 10;
      old_hi = m_hi;
      old_lo = m_lo;
      readHL = 2'b01;
      start = 1'b1; HILOop = {1'b0, op}; A = a; B = b;
      tick();
      start = 1'b0; HILOop = 4'd0;
      n = 0;
      while (busy === 1'b1 && n < 20) begin
         n++;
         chk("hlout_busy", HLout, (n % 2 == 1) ? old_hi : old_lo);
         A = $urandom; B = $urandom;
         start = 1'b0; HILOop = 4'd0;
         if (interfere && n == 2) begin
            start = 1'b1; HILOop = 4'($urandom_range(1, 6));
         end
         if (interfere && n == lat) begin
            start = 1'b1; HILOop = 4'd1;
         end
         readHL = (n % 2 == 0) ? 2'b01 : 2'b10;
         tick();
      end
      start = 1'b0; HILOop = 4'd0;
      chk("latency", 32'(n), 32'(lat));
      model_op(op, a, b);
      chk("res_hi", HI, m_hi);
      chk("res_lo", LO, m_lo);
      chk("idle_after", {31'd0, busy}, 32'd0);
      readHL = 2'b10; #1;
      chk("hlout_lo", HLout, m_lo);
      readHL = 2'b00; #1;
      chk("hlout_none", HLout, 32'd0);
   endtask

   initial begin
      logic [2:0]  rop;
      logic [31:0] ra, rb;
      reset = 1'b1; start = 1'b0; HILOop = 4'd0; A = 32'd0; B = 32'd0; readHL = 2'b00;
      tick();
      tick();
      reset = 1'b0;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_hi", HI, 32'd0);
      chk("rst_lo", LO, 32'd0);
      for (int i = 0; i < 4; i++) begin
         readHL = 2'(i); #1;
         chk("rst_hlout", HLout, 32'd0);
      end

      // mthi in idle, then read ports
      do_mt(4'd5, 32'hAAAA0000, 1'b0);
      chk("mthi_hi", HI, 32'hAAAA0000);
      readHL = 2'b01; #1; chk("mthi_hl01", HLout, 32'hAAAA0000);
      readHL = 2'b11; #1; chk("mthi_hl11", HLout, 32'd0);

      run_op(3'd1, 32'd7, 32'hFFFFFFFD, 1'b0);
      chk("mult_hi", HI, 32'hFFFFFFFF);
      chk("mult_lo", LO, 32'hFFFFFFEB);

      run_op(3'd2, 32'hFFFFFFFF, 32'd2, 1'b0);
      chk("multu_hi", HI, 32'h00000001);
      readHL = 2'b10; #1; chk("multu_hl10", HLout, 32'hFFFFFFFE);

      run_op(3'd3, 32'hFFFFFFF9, 32'd2, 1'b1);
      chk("div_lo", LO, 32'hFFFFFFFD);
      chk("div_hi", HI, 32'hFFFFFFFF);

      do_mt(4'd5, 32'h00001234, 1'b1);
      run_op(3'd4, 32'd7, 32'd0, 1'b0);
      chk("divu0_hi", HI, 32'h00001234);
      chk("divu0_lo", LO, 32'hFFFFFFFD);

      // reset in the middle of a multiply with interference at cycle 2
      start = 1'b1; HILOop = 4'd1; A = 32'd5; B = 32'd6;
      tick();
      start = 1'b0; HILOop = 4'd0;
      tick();
      start = 1'b1; HILOop = 4'd6; A = 32'hDEAD0000;
      tick();
      start = 1'b0; HILOop = 4'd0; reset = 1'b1;
      tick();
      reset = 1'b0;
      m_hi = 32'd0; m_lo = 32'd0;
      chk("mrst_busy", {31'd0, busy}, 32'd0);
      chk("mrst_hi", HI, 32'd0);
      chk("mrst_lo", LO, 32'd0);
      repeat (12) tick();
      chk("mrst_late_hi", HI, 32'd0);
      chk("mrst_late_lo", LO, 32'd0);
      chk("mrst_late_busy", {31'd0, busy}, 32'd0);

      for (int i = 0; i < 40; i++) begin
         rop = 3'($urandom_range(1, 6));
         if (rop >= 3'd5) begin
            do_mt({1'b0, rop}, $urandom, 1'($urandom_range(0, 1)));
         end else begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
               0: rb = 32'd0;
               1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
               2: rb = 32'($urandom_range(1, 9));
               3: rb = 32'd0 - 32'($urandom_range(1, 9));
               default: ;
            endcase
            run_op(rop, ra, rb, 1'($urandom_range(0, 1)));
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
